// File: rtl/stopwatch_sseg_src_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_sseg_src_if                                         |
// | Purpose  : Bundles the stopwatch buttons and display-side outputs.       |
// |            master = button/board side, slave = stopwatch core.           |
// | Signals  : go, clr             raw buttons (async, active-high)          |
// |            seg0..seg3 [6:0]    active-low segment patterns, bit0=a       |
// |            running             1 while counting                          |
// |            ovf                 sticky 9999->0000 wrap flag               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface stopwatch_sseg_src_if;
  logic       go;
  logic       clr;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic       running;
  logic       ovf;

  modport master (
    output go, clr,
    input  seg0, seg1, seg2, seg3, running, ovf
  );

  modport slave (
    input  go, clr,
    output seg0, seg1, seg2, seg3, running, ovf
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_sseg_src.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_sseg_src                                            |
// | Purpose  : Four-digit BCD stopwatch producing registered 7-segment       |
// |            patterns for a time-multiplexed display driver. Digit 0 is    |
// |            the rightmost (least significant) digit.                      |
// | Ports    : clk      system clock, rising edge                            |
// |            rst_n    asynchronous active-low reset                        |
// |            sw       stopwatch_sseg_src_if.slave (go, clr, seg0..3,       |
// |                     running, ovf)                                        |
// | Params   : TICK_DIV clk cycles per count increment (2..2^24)             |
// |            CNT_W    prescaler width, 2^CNT_W >= TICK_DIV                 |
// | Options  : LZ_BLANK_EN  define to blank leading zeros on seg3..seg1      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module stopwatch_sseg_src #(
  parameter int TICK_DIV = 500000,
  parameter int CNT_W    = 24
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  stopwatch_sseg_src_if.slave sw
);

  localparam logic [CNT_W-1:0] c_TICK_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]       c_GLYPH0   = 7'b1000000;
  localparam logic [6:0]       c_BLANK    = 7'b1111111;
`ifdef LZ_BLANK_EN
  localparam logic [6:0]       c_LEAD_RST = c_BLANK;
`else
  localparam logic [6:0]       c_LEAD_RST = c_GLYPH0;
`endif

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Button conditioning: s1/s2 resolve metastability, s3 is the previous
  // sample so s2 & ~s3 gives one pulse per press however long it is held.
  // ---------------------------------------------------------------------
  logic r_go_s1, r_go_s2, r_go_s3;
  logic r_clr_s1, r_clr_s2, r_clr_s3;
  logic w_go_pulse, w_clr_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go_s1  <= 1'b0;
      r_go_s2  <= 1'b0;
      r_go_s3  <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
      r_clr_s3 <= 1'b0;
    end else begin
      r_go_s1  <= sw.go;
      r_go_s2  <= r_go_s1;
      r_go_s3  <= r_go_s2;
      r_clr_s1 <= sw.clr;
      r_clr_s2 <= r_clr_s1;
      r_clr_s3 <= r_clr_s2;
    end
  end

  assign w_go_pulse  = r_go_s2 & ~r_go_s3;
  assign w_clr_pulse = r_clr_s2 & ~r_clr_s3;

  // ---------------------------------------------------------------------
  // BCD increment with ripple carry across all four digits in one cycle.
  // ---------------------------------------------------------------------
  logic [3:0][3:0] r_dig;
  logic [3:0][3:0] w_dig_inc;
  logic            w_carry;
  logic            w_wrap;

  always_comb begin
    w_dig_inc = r_dig;
    w_carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_dig[i] == 4'd9) begin
          w_dig_inc[i] = 4'd0;
        end else begin
          w_dig_inc[i] = r_dig[i] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
  end

  // Carry out of digit 3 means 9999 -> 0000.
  assign w_wrap = (r_dig == 16'h9999);

  // ---------------------------------------------------------------------
  // Control FSM, prescaler and digit counter. clr has priority over both
  // go and a coincident tick. The prescaler only advances in RUN, so a
  // partial interval survives a pause.
  // ---------------------------------------------------------------------
  state_t           r_state;
  logic             r_running;
  logic             r_ovf;
  logic [CNT_W-1:0] r_presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
      r_presc   <= '0;
      r_dig     <= '0;
    end else if (w_clr_pulse) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
      r_presc   <= '0;
      r_dig     <= '0;
    end else begin
      if (r_state == ST_RUN) begin
        if (r_presc == c_TICK_MAX) begin
          r_presc <= '0;
          r_dig   <= w_dig_inc;
          if (w_wrap) begin
            r_ovf <= 1'b1;
          end
        end else begin
          r_presc <= r_presc + CNT_W'(1);
        end
      end
      if (w_go_pulse) begin
        if (r_state == ST_RUN) begin
          r_state   <= ST_STOP;
          r_running <= 1'b0;
        end else begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Segment encoding (active-low, bit6=g .. bit0=a), one register stage.
  // ---------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // A digit is blanked when it and every more-significant digit are zero.
  logic [3:0] w_blank;

  always_comb begin
    w_blank = 4'b0000;
`ifdef LZ_BLANK_EN
    w_blank[3] = (r_dig[3] == 4'd0);
    w_blank[2] = w_blank[3] && (r_dig[2] == 4'd0);
    w_blank[1] = w_blank[2] && (r_dig[1] == 4'd0);
`endif
  end

  logic [6:0] r_seg [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg[0] <= c_GLYPH0;
      for (int i = 1; i < 4; i++) begin
        r_seg[i] <= c_LEAD_RST;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_seg[i] <= w_blank[i] ? c_BLANK : glyph(r_dig[i]);
      end
    end
  end

  assign sw.seg0    = r_seg[0];
  assign sw.seg1    = r_seg[1];
  assign sw.seg2    = r_seg[2];
  assign sw.seg3    = r_seg[3];
  assign sw.running = r_running;
  assign sw.ovf     = r_ovf;

endmodule
`default_nettype wire

// File: doc/stopwatch_sseg_src.md
Name: stopwatch_sseg_src

Overview:
- Four-digit BCD stopwatch that produces the segment patterns for the four-digit time-multiplexed display driver.
- Sits directly upstream of the display multiplexer. seg0..seg3 connect straight to its in0..in3.
- Digit 0 is the rightmost display and the least significant digit.
- Start/stop and clear come from raw board buttons. The block synchronises them internally.

Parameters:
- TICK_DIV, 500000: clk cycles per count increment (100 Hz at 50 MHz). Legal range 2..2^24.
- CNT_W, 24: prescaler width. Must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- go  in  1  raw start/stop button, asynchronous to clk, active-high
- clr  in  1  raw clear button, asynchronous to clk, active-high
- seg0  out  7  digit 0 segments, active-low, bit0=a .. bit6=g
- seg1  out  7  digit 1 segments
- seg2  out  7  digit 2 segments
- seg3  out  7  digit 3 segments
- running  out  1  1 while in RUN
- ovf  out  1  sticky flag: count wrapped 9999 -> 0000

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=STOP, digits=0000, prescaler=0, all sync flops=0, running=0, ovf=0.
  - seg0..seg3 = 7'b1000000 (the "0" glyph).
  - Release is sampled on the next rising edge of clk.
- Input conditioning, applied to go and clr separately:
  - Three-flop chain s1->s2->s3.
  - Edge pulse = s2 & ~s3, one cycle wide.
  - Input high before clk edge k => pulse active in the cycle after edge k+1 => acted on at edge k+2.
  - A held button produces exactly one pulse.
- State machine, two states STOP and RUN:
  - STOP + go pulse -> RUN.
  - RUN + go pulse -> STOP.
  - clr pulse in either state -> STOP, digits=0000, prescaler=0, ovf=0.
  - go and clr pulses in the same cycle: clr wins, final state is STOP.
  - running = (state==RUN), registered, same edge as the state change.
- Prescaler:
  - In RUN, increments each cycle.
  - When prescaler==TICK_DIV-1: prescaler returns to 0 and the digits increment on that same edge.
  - In STOP, the prescaler holds its value, so the partial interval is kept across a pause.
- Digit arithmetic:
  - Each digit is 4-bit BCD, 0..9.
  - Digit 0 increments. A 9->0 transition carries into the next digit, ripple within one cycle.
  - 9999 + 1 -> 0000, and ovf is set on the same edge. ovf stays set until clr or reset.
  - Digits never hold values 10..15.
- Segment encoding, registered:
  - segN updates on the edge after its digit changes, giving 1 cycle latency from digit to segment.
  - Glyphs, active-low, bit order g..a:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- A clr pulse coinciding with a tick: clr wins, the digits become 0000 and no increment occurs.
- rst_n asserted mid-count: all state clears immediately, with no glitch dependence on clk.

Optional Feature:
- Macro LZ_BLANK_EN, leading-zero blanking.
- With LZ_BLANK_EN defined:
  - seg3 is blank (7'b1111111) when digit3==0.
  - seg2 is blank when digit3 and digit2 are both 0.
  - seg1 is blank when digits 3..1 are all 0.
  - seg0 is never blanked.
  - Blanking is evaluated in the same registered stage as the segment encoding; the 1-cycle latency is unchanged.
  - Reset value is seg3..seg1 = 7'b1111111, seg0 = 7'b1000000.
- Without LZ_BLANK_EN: all four digits always show their glyph, including leading zeros.

Test Plan (TICK_DIV=4):
- Reset, then go held for 3 cycles -> running=1 three edges after go rises. After 4 RUN cycles, seg0=1111001 ("1") one cycle after the digit update. The rest of the segments stay "0".
- Run 40 ticks, then pulse go -> running=0. Digits freeze at 0040: seg1=0011001, seg0=1000000. Pulse go again -> the next increment arrives after the remaining prescaler cycles, not a full 4.
- Force digits to 9999 while in RUN, then let one tick pass -> all segs "0" and ovf=1. Then pulse clr -> ovf=0, STOP.
- go and clr rising on the same cycle while in STOP -> state stays STOP, digits 0000, running=0.
- Assert rst_n=0 asynchronously mid-prescale while at 0123 -> outputs return to reset values before the next clk edge. After release, nothing counts until a go pulse.
- LZ_BLANK_EN defined, count to 0007 -> seg3..seg1=1111111, seg0=1111000. Count to 0010 -> seg1=1111001, seg3 and seg2 blank.
